// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: decodes START/STOP, matches a 7-bit write address, ACKs and
// hands received bytes to a valid/ready consumer; outputs react one clk after the bus event.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         MAX_BYTES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda_in,
  input  logic       scl_in,
  input  logic       past_sda_in,
  input  logic       past_scl_in,
  input  logic       rx_ready,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       rx_stop,
  output logic       busy
);

  localparam int            CW    = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t        state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [CW-1:0] byte_cnt, byte_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          acked, acked_n;
  logic          sda_oe_n, rx_valid_n, rx_first_n, rx_stop_n;
  logic [7:0]    rx_data_n;

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_in & ~past_scl_in;
  assign scl_fall = ~scl_in & past_scl_in;
  assign start    = scl_in & past_scl_in & past_sda_in & ~sda_in;
  assign stop     = scl_in & past_scl_in & ~past_sda_in & sda_in;

  assign busy = (state != IDLE);

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    shreg_n    = shreg;
    acked_n    = acked;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_first_n = rx_first;
    rx_stop_n  = 1'b0;

    if (stop) begin
      rx_stop_n = acked && (state == DATA || state == DATA_ACK || state == IGNORE);
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      acked_n   = 1'b0;
      bit_cnt_n = 4'd0;
    end else if (start) begin
      state_n    = ADDR;
      sda_oe_n   = 1'b0;
      acked_n    = 1'b0;
      bit_cnt_n  = 4'd0;
      byte_cnt_n = '0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_n   = {shreg[6:0], sda_in};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (state == ADDR) begin
              if (shreg[7:1] == SLAVE_ADDR && !shreg[0]) begin
                state_n  = ADDR_ACK;
                sda_oe_n = 1'b1;
                acked_n  = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end else if (rx_ready && byte_cnt < MAX_C) begin
              rx_data_n  = shreg;
              rx_valid_n = 1'b1;
              rx_first_n = (byte_cnt == '0);
              byte_cnt_n = byte_cnt + CW'(1);
              sda_oe_n   = 1'b1;
              state_n    = DATA_ACK;
            end else begin
              // Consumer stalled or byte limit reached: NACK by leaving SDA released
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = DATA;
          end
        end
        IGNORE:  sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      byte_cnt <= '0;
      shreg    <= 8'd0;
      acked    <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      rx_stop  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      shreg    <= shreg_n;
      acked    <= acked_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rx_first <= rx_first_n;
      rx_stop  <= rx_stop_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a default instance and a MAX_BYTES=2 instance share one bus.
module tb_i2c_slave_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sda = 1'b1, scl = 1'b1, past_sda = 1'b1, past_scl = 1'b1;
  logic rx_ready = 1'b1;

  logic       oe, valid, first, stp, bsy;
  logic [7:0] data;
  logic       oe2, valid2, first2, stp2, bsy2;
  logic [7:0] data2;

  always @(posedge clk) begin
    past_sda <= sda;
    past_scl <= scl;
  end

  i2c_slave_rx dut (
    .clk(clk), .rst(rst), .sda_in(sda), .scl_in(scl),
    .past_sda_in(past_sda), .past_scl_in(past_scl), .rx_ready(rx_ready),
    .sda_oe(oe), .rx_data(data), .rx_valid(valid), .rx_first(first),
    .rx_stop(stp), .busy(bsy)
  );

  i2c_slave_rx #(.SLAVE_ADDR(7'h2A), .MAX_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .sda_in(sda), .scl_in(scl),
    .past_sda_in(past_sda), .past_scl_in(past_scl), .rx_ready(rx_ready),
    .sda_oe(oe2), .rx_data(data2), .rx_valid(valid2), .rx_first(first2),
    .rx_stop(stp2), .busy(bsy2)
  );

  // Event recorder: {rx_first, rx_data} per rx_valid pulse, rx_stop count, any sda_oe
  logic [8:0] vq[$];
  logic [8:0] vq2[$];
  int stop_cnt = 0, stop_cnt2 = 0;
  logic oe_seen = 1'b0;

  always @(negedge clk) begin
    if (valid)  vq.push_back({first, data});
    if (valid2) vq2.push_back({first2, data2});
    if (stp)    stop_cnt++;
    if (stp2)   stop_cnt2++;
    if (oe)     oe_seen = 1'b1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] qget(input int which, input int i);
    if (which == 0) return (vq.size() > i) ? vq[i] : 9'h1FF;
    return (vq2.size() > i) ? vq2[i] : 9'h1FF;
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    vq.delete();
    vq2.delete();
    stop_cnt  = 0;
    stop_cnt2 = 0;
    oe_seen   = 1'b0;
  endtask

  task automatic i2c_start();
    sda = 1'b1; wclk(2);
    scl = 1'b1; wclk(2);
    sda = 1'b0; wclk(2);
    scl = 1'b0; wclk(2);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; wclk(2);
    scl = 1'b1; wclk(2);
    sda = 1'b1; wclk(4);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    wclk(2);
    scl = 1'b1; wclk(2);
    scl = 1'b0; wclk(2);
  endtask

  // 8 data bits then the ACK clock; sda_oe of both instances is checked mid-ACK-high
  task automatic send_byte(input logic [7:0] d, input logic a1, input logic a2, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda = 1'b1; wclk(2);
    scl = 1'b1; wclk(1);
    check({tag, "_ack"}, 32'(oe), 32'(a1));
    check({tag, "_ack2"}, 32'(oe2), 32'(a2));
    wclk(1);
    scl = 1'b0; wclk(2);
  endtask

  initial begin
    logic [7:0] addr_byte;

    // Reset state
    wclk(3);
    check("rst_oe", 32'(oe), 0);
    check("rst_busy", 32'(bsy), 0);
    check("rst_data", 32'(data), 0);
    check("rst_pulses", {29'd0, valid, first, stp}, 0);
    rst = 1'b0;
    wclk(2);
    check("idle_busy", 32'(bsy), 0);

    // T1: reset while the address ACK is being driven
    clr();
    i2c_start();
    addr_byte = 8'h54;
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i]);
    sda = 1'b1; wclk(2);
    scl = 1'b1; wclk(1);
    check("t1_oe_before", 32'(oe), 1);
    rst = 1'b1; wclk(1);
    check("t1_oe_after", 32'(oe), 0);
    check("t1_busy_after", 32'(bsy), 0);
    check("t1_pulses", {29'd0, valid, first, stp}, 0);
    rst = 1'b0; wclk(4);

    // T2: address 0x2A+W, bytes 0x10 and 0x5A, STOP
    clr();
    i2c_start();
    check("t2_busy", 32'(bsy), 1);
    send_byte(8'h54, 1'b1, 1'b1, "t2_addr");
    send_byte(8'h10, 1'b1, 1'b1, "t2_b0");
    send_byte(8'h5A, 1'b1, 1'b1, "t2_b1");
    i2c_stop();
    check("t2_nvalid", vq.size(), 2);
    check("t2_v0", 32'(qget(0, 0)), 32'h110);
    check("t2_v1", 32'(qget(0, 1)), 32'h05A);
    check("t2_stop", stop_cnt, 1);
    check("t2_busy_end", 32'(bsy), 0);
    check("t2_oe_end", 32'(oe), 0);

    // T3: wrong address, then correct address with read bit
    clr();
    i2c_start();
    send_byte(8'h56, 1'b0, 1'b0, "t3_addr2b");
    send_byte(8'h11, 1'b0, 1'b0, "t3_data2b");
    i2c_stop();
    i2c_start();
    send_byte(8'h55, 1'b0, 1'b0, "t3_addr_rd");
    check("t3_ignore_busy", 32'(bsy), 1);
    send_byte(8'h22, 1'b0, 1'b0, "t3_data_rd");
    i2c_stop();
    check("t3_oe_seen", 32'(oe_seen), 0);
    check("t3_nvalid", vq.size(), 0);
    check("t3_stop", stop_cnt, 0);
    check("t3_busy_end", 32'(bsy), 0);

    // T4: consumer not ready at end of first data byte
    clr();
    i2c_start();
    send_byte(8'h54, 1'b1, 1'b1, "t4_addr");
    rx_ready = 1'b0;
    send_byte(8'h77, 1'b0, 1'b0, "t4_b0");
    rx_ready = 1'b1;
    check("t4_ignore_busy", 32'(bsy), 1);
    i2c_stop();
    check("t4_nvalid", vq.size(), 0);
    check("t4_stop", stop_cnt, 1);
    check("t4_busy_end", 32'(bsy), 0);

    // T5: three bytes; the MAX_BYTES=2 instance NACKs the third
    clr();
    i2c_start();
    send_byte(8'h54, 1'b1, 1'b1, "t5_addr");
    send_byte(8'hA1, 1'b1, 1'b1, "t5_b0");
    send_byte(8'hB2, 1'b1, 1'b1, "t5_b1");
    send_byte(8'hC3, 1'b1, 1'b0, "t5_b2");
    i2c_stop();
    check("t5_nvalid2", vq2.size(), 2);
    check("t5_v2_0", 32'(qget(1, 0)), 32'h1A1);
    check("t5_v2_1", 32'(qget(1, 1)), 32'h0B2);
    check("t5_stop2", stop_cnt2, 1);
    check("t5_nvalid", vq.size(), 3);
    check("t5_v_2", 32'(qget(0, 2)), 32'h0C3);

    // T6: repeated START after 3 data bits discards the partial byte
    clr();
    i2c_start();
    send_byte(8'h54, 1'b1, 1'b1, "t6_addr");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_start();
    check("t6_rs_oe", 32'(oe), 0);
    send_byte(8'h54, 1'b1, 1'b1, "t6_addr_rs");
    send_byte(8'h33, 1'b1, 1'b1, "t6_b0");
    i2c_stop();
    check("t6_nvalid", vq.size(), 1);
    check("t6_v0", 32'(qget(0, 0)), 32'h133);
    check("t6_stop", stop_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
